nvme_cq_handler: RTL and testbench



---
 rtl/nvme_cq_handler.sv | 145 ++++++++++++++
 tb/tb_nvme_cq_handler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvme_cq_handler.sv
// nvme_cq_handler: absorbs NVMe CQ entries over AXI4, retires host write responses in command order,
// and rings the CQ head doorbell over AXI-Lite.
module nvme_cq_handler #(
    parameter int          NS_ID_WIDTH   = 4,
    parameter int          NS_ADDR_WIDTH = 32,
    parameter int          NS_DATA_WIDTH = 128,
    parameter int          NL_ADDR_WIDTH = 32,
    parameter int          NL_DATA_WIDTH = 32,
    parameter int          OUTSTANDING   = 16,
    parameter logic [31:0] CQ_DB_ADDR    = 32'h0000_100C
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NS_ID_WIDTH-1:0]       ns_awid,
    input  logic [NS_ADDR_WIDTH-1:0]     ns_awaddr,
    input  logic [7:0]                   ns_awlen,
    input  logic [2:0]                   ns_awsize,
    input  logic [1:0]                   ns_awburst,
    input  logic                         ns_awvalid,
    output logic                         ns_awready,
    input  logic [NS_DATA_WIDTH-1:0]     ns_wdata,
    input  logic [NS_DATA_WIDTH/8-1:0]   ns_wstrb,
    input  logic                         ns_wlast,
    input  logic                         ns_wvalid,
    output logic                         ns_wready,
    output logic [NS_ID_WIDTH-1:0]       ns_bid,
    output logic [1:0]                   ns_bresp,
    output logic                         ns_bvalid,
    input  logic                         ns_bready,
    output logic [NL_ADDR_WIDTH-1:0]     nl_awaddr,
    output logic                         nl_awvalid,
    input  logic                         nl_awready,
    output logic [NL_DATA_WIDTH-1:0]     nl_wdata,
    output logic [NL_DATA_WIDTH/8-1:0]   nl_wstrb,
    output logic                         nl_wvalid,
    input  logic                         nl_wready,
    input  logic [1:0]                   nl_bresp,
    input  logic                         nl_bvalid,
    output logic                         nl_bready,
    output logic [1:0]                   hp_bresp,
    output logic                         hp_bvalid,
    input  logic                         hp_bready,
    output logic [$clog2(OUTSTANDING)-1:0] cqdb_sqhead,
    output logic [15:0]                  err_count
);
    localparam int IW = $clog2(OUTSTANDING);
    localparam logic [1:0] S_IDLE = 2'd0, S_DATA = 2'd1, S_RESP = 2'd2;
    localparam logic [1:0] D_IDLE = 2'd0, D_SEND = 2'd1, D_WAIT = 2'd2;

    logic [1:0]             s_st, d_st;
    logic [OUTSTANDING-1:0] done, err;
    logic [IW-1:0]          cq_head, db_head, rp, cid;
    logic                   exp_phase, beat, stale, dup, beat_err, nl_err, ret;
    logic [1:0]             err_inc;
    logic [16:0]            err_sum;
    logic                   unused;

    assign beat        = ns_wvalid && ns_wready;
    assign cid         = ns_wdata[96 +: IW];
    assign stale       = ns_wdata[112] != exp_phase;
    // done[rp] is still set in the cycle it retires, so a same-slot beat reads as a duplicate
    assign dup         = done[cid];
    assign beat_err    = beat && (stale || dup);
    assign nl_err      = d_st == D_WAIT && nl_bvalid && nl_bresp != 2'b00;
    assign ret         = hp_bvalid && hp_bready;
    assign err_inc     = {1'b0, beat_err} + {1'b0, nl_err};
    assign err_sum     = {1'b0, err_count} + {15'b0, err_inc};
    assign ns_awready  = s_st == S_IDLE;
    assign ns_wready   = s_st == S_DATA;
    assign ns_bvalid   = s_st == S_RESP;
    assign ns_bresp    = 2'b00;
    assign hp_bvalid   = done[rp];
    assign hp_bresp    = err[rp] ? 2'b10 : 2'b00;
    assign cqdb_sqhead = rp;
    assign nl_bready   = d_st == D_WAIT;
    assign unused      = ^{ns_awaddr, ns_awlen, ns_awsize, ns_awburst, ns_wstrb, ns_wdata};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_st   <= S_IDLE;
            ns_bid <= '0;
        end else if (ns_awvalid && ns_awready) begin
            s_st   <= S_DATA;
            ns_bid <= ns_awid;
        end else if (beat && ns_wlast) begin
            s_st <= S_RESP;
        end else if (ns_bvalid && ns_bready) begin
            s_st <= S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done      <= '0;
            err       <= '0;
            cq_head   <= '0;
            exp_phase <= 1'b1;
            rp        <= '0;
            err_count <= '0;
        end else begin
            if (ret) begin
                done[rp] <= 1'b0;
                rp       <= rp + IW'(1);
            end
            if (beat && !stale) begin
                cq_head <= cq_head + IW'(1);
                if (&cq_head) exp_phase <= !exp_phase;
                if (!dup) begin
                    done[cid] <= 1'b1;
                    err[cid]  <= ns_wdata[127:113] != '0;
                end
            end
            err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    // one doorbell in flight; head moves during SEND/WAIT are picked up by the next write
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            d_st       <= D_IDLE;
            db_head    <= '0;
            nl_awvalid <= 1'b0;
            nl_wvalid  <= 1'b0;
            nl_awaddr  <= '0;
            nl_wdata   <= '0;
            nl_wstrb   <= '0;
        end else if (d_st == D_IDLE) begin
            if (cq_head != db_head) begin
                d_st       <= D_SEND;
                db_head    <= cq_head;
                nl_awvalid <= 1'b1;
                nl_wvalid  <= 1'b1;
                nl_awaddr  <= NL_ADDR_WIDTH'(CQ_DB_ADDR);
                nl_wdata   <= NL_DATA_WIDTH'(cq_head);
                nl_wstrb   <= '1;
            end
        end else if (d_st == D_SEND) begin
            if (nl_awready) nl_awvalid <= 1'b0;
            if (nl_wready) nl_wvalid <= 1'b0;
            if ((!nl_awvalid || nl_awready) && (!nl_wvalid || nl_wready)) d_st <= D_WAIT;
        end else if (nl_bvalid) begin
            d_st <= D_IDLE;
        end
    end
endmodule

// File: tb/tb_nvme_cq_handler.sv
// tb_nvme_cq_handler: directed scenarios for the CQ handler with hand-computed expectations.
module tb_nvme_cq_handler;
    logic         clk = 1'b0, rstn = 1'b0;
    logic [3:0]   ns_awid = '0;
    logic [31:0]  ns_awaddr = '0;
    logic [7:0]   ns_awlen = '0;
    logic [2:0]   ns_awsize = 3'd4;
    logic [1:0]   ns_awburst = 2'b01;
    logic         ns_awvalid = 1'b0, ns_awready;
    logic [127:0] ns_wdata = '0;
    logic [15:0]  ns_wstrb = '1;
    logic         ns_wlast = 1'b0, ns_wvalid = 1'b0, ns_wready;
    logic [3:0]   ns_bid;
    logic [1:0]   ns_bresp;
    logic         ns_bvalid, ns_bready = 1'b0;
    logic [31:0]  nl_awaddr;
    logic         nl_awvalid, nl_awready = 1'b1;
    logic [31:0]  nl_wdata;
    logic [3:0]   nl_wstrb;
    logic         nl_wvalid, nl_wready = 1'b1;
    logic [1:0]   nl_bresp = 2'b00;
    logic         nl_bvalid = 1'b0, nl_bready;
    logic [1:0]   hp_bresp;
    logic         hp_bvalid, hp_bready = 1'b0;
    logic [3:0]   cqdb_sqhead;
    logic [15:0]  err_count;

    int           checks = 0, errors = 0;
    int           ret_cnt, nsb_cnt, db_aw_cnt, db_w_cnt;
    logic [1:0]   resp_log [32];
    logic [31:0]  db_data [32];
    logic [3:0]   last_bid;
    logic [1:0]   db_resp = 2'b00;

    nvme_cq_handler dut (
        .clk(clk), .rstn(rstn),
        .ns_awid(ns_awid), .ns_awaddr(ns_awaddr), .ns_awlen(ns_awlen), .ns_awsize(ns_awsize),
        .ns_awburst(ns_awburst), .ns_awvalid(ns_awvalid), .ns_awready(ns_awready),
        .ns_wdata(ns_wdata), .ns_wstrb(ns_wstrb), .ns_wlast(ns_wlast), .ns_wvalid(ns_wvalid),
        .ns_wready(ns_wready), .ns_bid(ns_bid), .ns_bresp(ns_bresp), .ns_bvalid(ns_bvalid),
        .ns_bready(ns_bready), .nl_awaddr(nl_awaddr), .nl_awvalid(nl_awvalid), .nl_awready(nl_awready),
        .nl_wdata(nl_wdata), .nl_wstrb(nl_wstrb), .nl_wvalid(nl_wvalid), .nl_wready(nl_wready),
        .nl_bresp(nl_bresp), .nl_bvalid(nl_bvalid), .nl_bready(nl_bready),
        .hp_bresp(hp_bresp), .hp_bvalid(hp_bvalid), .hp_bready(hp_bready),
        .cqdb_sqhead(cqdb_sqhead), .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // handshakes are counted at negedge, where inputs and outputs are both stable
    always @(negedge clk) begin
        if (!rstn) begin
            ret_cnt = 0; nsb_cnt = 0; db_aw_cnt = 0; db_w_cnt = 0;
        end else begin
            if (hp_bvalid && hp_bready) begin resp_log[ret_cnt] = hp_bresp; ret_cnt++; end
            if (ns_bvalid && ns_bready) begin last_bid = ns_bid; nsb_cnt++; end
            if (nl_awvalid && nl_awready) db_aw_cnt++;
            if (nl_wvalid && nl_wready) begin db_data[db_w_cnt] = nl_wdata; db_w_cnt++; end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (!rstn || nl_bvalid) nl_bvalid = 1'b0;
        else if (nl_bready) begin nl_bvalid = 1'b1; nl_bresp = db_resp; end
    end

    function automatic logic [127:0] ent(input int cid, input logic ph, input logic [14:0] st);
        return {st, ph, 16'(cid), 96'h0};
    endfunction

    task automatic cycles(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        ns_awvalid = 1'b0; ns_wvalid = 1'b0; ns_wlast = 1'b0; ns_bready = 1'b0; hp_bready = 1'b0;
        nl_awready = 1'b1; nl_wready = 1'b1; db_resp = 2'b00;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        cycles(1);
    endtask

    task automatic aw(input logic [3:0] id);
        int n;
        logic ok;
        n = 0;
        ns_awid = id; ns_awvalid = 1'b1;
        do begin @(negedge clk); ok = ns_awready; @(posedge clk); #1; n++; end while (!ok && n < 50);
        ns_awvalid = 1'b0;
        if (!ok) begin errors++; $display("FAIL aw_timeout: awready never seen"); end
    endtask

    task automatic wb(input logic [127:0] d, input logic last);
        int n;
        logic ok;
        n = 0;
        ns_wdata = d; ns_wlast = last; ns_wvalid = 1'b1;
        do begin @(negedge clk); ok = ns_wready; @(posedge clk); #1; n++; end while (!ok && n < 50);
        ns_wvalid = 1'b0; ns_wlast = 1'b0;
        if (!ok) begin errors++; $display("FAIL w_timeout: wready never seen"); end
    endtask

    task automatic bb();
        int n;
        logic ok;
        n = 0;
        ns_bready = 1'b1;
        do begin @(negedge clk); ok = ns_bvalid; @(posedge clk); #1; n++; end while (!ok && n < 50);
        ns_bready = 1'b0;
        if (!ok) begin errors++; $display("FAIL b_timeout: bvalid never seen"); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if ({ns_awready, ns_wready, ns_bvalid, hp_bvalid, nl_awvalid, nl_wvalid, nl_bready} !== 7'b1000000) begin errors++; $display("FAIL reset_flags: got %b want 1000000", {ns_awready, ns_wready, ns_bvalid, hp_bvalid, nl_awvalid, nl_wvalid, nl_bready}); end
        checks++; if ({cqdb_sqhead, err_count} !== 20'h0) begin errors++; $display("FAIL reset_counters: got %h want 0", {cqdb_sqhead, err_count}); end
        checks++; if ({nl_awaddr, nl_wdata, nl_wstrb, ns_bid, ns_bresp, hp_bresp} !== 78'h0) begin errors++; $display("FAIL reset_buses: got %h want 0", {nl_awaddr, nl_wdata, nl_wstrb, ns_bid, ns_bresp, hp_bresp}); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        aw(4'h5);
        wb(ent(0, 1'b1, 15'h0), 1'b1);
        checks++; if ({hp_bvalid, hp_bresp} !== 3'b100) begin errors++; $display("FAIL single_hp_b: got %b want 100", {hp_bvalid, hp_bresp}); end
        checks++; if ({ns_bvalid, ns_bid, ns_bresp} !== 7'b1_0101_00) begin errors++; $display("FAIL single_ns_b: got %b want 1010100", {ns_bvalid, ns_bid, ns_bresp}); end
        checks++; if ({nl_awvalid, nl_wvalid} !== 2'b00) begin errors++; $display("FAIL db_early: got %b want 00", {nl_awvalid, nl_wvalid}); end
        cycles(1);
        checks++; if ({nl_awvalid, nl_wvalid, nl_awaddr, nl_wdata, nl_wstrb} !== {2'b11, 32'h100C, 32'h1, 4'hF}) begin errors++; $display("FAIL db_launch: got %b %h %h %h want 11 100c 1 f", {nl_awvalid, nl_wvalid}, nl_awaddr, nl_wdata, nl_wstrb); end
        bb();
        checks++; if (ns_awready !== 1'b1) begin errors++; $display("FAIL awready_after_b: got %b want 1", ns_awready); end
        hp_bready = 1'b1;
        cycles(1);
        hp_bready = 1'b0;
        checks++; if ({hp_bvalid, cqdb_sqhead} !== 5'b0_0001) begin errors++; $display("FAIL single_retire: got %b want 00001", {hp_bvalid, cqdb_sqhead}); end
        cycles(5);
        checks++; if (db_aw_cnt !== 1 || db_w_cnt !== 1 || db_data[0] !== 32'h1) begin errors++; $display("FAIL single_db: got aw=%0d w=%0d data=%h want 1 1 1", db_aw_cnt, db_w_cnt, db_data[0]); end
        checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL single_err: got %0d want 0", err_count); end
    endtask

    task automatic test_out_of_order();
        do_reset();
        aw(4'h9);
        wb(ent(2, 1'b1, 15'h0), 1'b0);
        checks++; if (hp_bvalid !== 1'b0) begin errors++; $display("FAIL ooo_wait_cid2: got %b want 0", hp_bvalid); end
        wb(ent(1, 1'b1, 15'h0), 1'b0);
        checks++; if (hp_bvalid !== 1'b0) begin errors++; $display("FAIL ooo_wait_cid1: got %b want 0", hp_bvalid); end
        wb(ent(0, 1'b1, 15'h0), 1'b1);
        checks++; if ({hp_bvalid, ns_bvalid, ns_bid} !== 6'b11_1001) begin errors++; $display("FAIL ooo_cid0_land: got %b want 111001", {hp_bvalid, ns_bvalid, ns_bid}); end
        bb();
        hp_bready = 1'b1;
        cycles(3);
        hp_bready = 1'b0;
        checks++; if (ret_cnt !== 3 || {resp_log[0], resp_log[1], resp_log[2]} !== 6'b0) begin errors++; $display("FAIL ooo_retire: got cnt=%0d resp=%b want 3 000000", ret_cnt, {resp_log[0], resp_log[1], resp_log[2]}); end
        checks++; if ({hp_bvalid, cqdb_sqhead} !== 5'b0_0011) begin errors++; $display("FAIL ooo_sqhead: got %b want 00011", {hp_bvalid, cqdb_sqhead}); end
        checks++; if (nsb_cnt !== 1 || last_bid !== 4'h9) begin errors++; $display("FAIL ooo_ns_b: got cnt=%0d bid=%h want 1 9", nsb_cnt, last_bid); end
    endtask

    task automatic test_status();
        do_reset();
        aw(4'h1);
        for (int i = 0; i < 3; i++) wb(ent(i, 1'b1, 15'h0), 1'b0);
        wb(ent(3, 1'b1, 15'h1), 1'b1);
        bb();
        hp_bready = 1'b1;
        cycles(4);
        hp_bready = 1'b0;
        checks++; if (ret_cnt !== 4) begin errors++; $display("FAIL status_count: got %0d want 4", ret_cnt); end
        checks++; if (resp_log[3] !== 2'b10) begin errors++; $display("FAIL status_slverr: got %b want 10", resp_log[3]); end
        checks++; if ({resp_log[0], resp_log[1], resp_log[2]} !== 6'b0) begin errors++; $display("FAIL status_okay: got %b want 000000", {resp_log[0], resp_log[1], resp_log[2]}); end
    endtask

    task automatic test_wrap();
        do_reset();
        hp_bready = 1'b1;
        aw(4'h2);
        for (int i = 0; i < 16; i++) wb(ent(i, 1'b1, 15'h0), i == 15);
        bb();
        cycles(12);
        checks++; if (ret_cnt !== 16 || err_count !== 16'h0) begin errors++; $display("FAIL wrap_fill: got cnt=%0d err=%0d want 16 0", ret_cnt, err_count); end
        checks++; if (db_w_cnt < 1 || db_data[db_w_cnt-1] !== 32'h0) begin errors++; $display("FAIL wrap_db_zero: got writes=%0d last=%h want head 0", db_w_cnt, db_data[db_w_cnt-1]); end
        aw(4'h2); wb(ent(0, 1'b1, 15'h0), 1'b1); bb();
        cycles(3);
        checks++; if (err_count !== 16'h1 || ret_cnt !== 16 || hp_bvalid !== 1'b0) begin errors++; $display("FAIL wrap_stale: got err=%0d cnt=%0d hp=%b want 1 16 0", err_count, ret_cnt, hp_bvalid); end
        aw(4'h2); wb(ent(0, 1'b0, 15'h0), 1'b1); bb();
        cycles(8);
        checks++; if (err_count !== 16'h1 || ret_cnt !== 17) begin errors++; $display("FAIL wrap_accept: got err=%0d cnt=%0d want 1 17", err_count, ret_cnt); end
        checks++; if (db_data[db_w_cnt-1] !== 32'h1) begin errors++; $display("FAIL wrap_head: got %h want 1", db_data[db_w_cnt-1]); end
    endtask

    task automatic test_coalesce();
        do_reset();
        hp_bready = 1'b1;
        nl_awready = 1'b0;
        db_resp = 2'b10;
        aw(4'h3);
        for (int i = 0; i < 5; i++) wb(ent(i, 1'b1, 15'h0), i == 4);
        bb();
        cycles(12);
        checks++; if (db_aw_cnt !== 0 || nl_awvalid !== 1'b1) begin errors++; $display("FAIL coal_stall: got aw=%0d awvalid=%b want 0 1", db_aw_cnt, nl_awvalid); end
        nl_awready = 1'b1;
        cycles(15);
        checks++; if (db_aw_cnt !== 2 || db_w_cnt !== 2) begin errors++; $display("FAIL coal_count: got aw=%0d w=%0d want 2 2", db_aw_cnt, db_w_cnt); end
        checks++; if (db_data[0] !== 32'h1 || db_data[1] !== 32'h5) begin errors++; $display("FAIL coal_heads: got %h %h want 1 5", db_data[0], db_data[1]); end
        checks++; if (err_count !== 16'h2) begin errors++; $display("FAIL coal_bresp_err: got %0d want 2", err_count); end
    endtask

    task automatic test_duplicate();
        do_reset();
        aw(4'h6);
        for (int i = 0; i < 5; i++) wb(ent(i, 1'b1, 15'h0), 1'b0);
        wb(ent(4, 1'b1, 15'h0), 1'b1);
        checks++; if (err_count !== 16'h1) begin errors++; $display("FAIL dup_err: got %0d want 1", err_count); end
        bb();
        hp_bready = 1'b1;
        cycles(8);
        hp_bready = 1'b0;
        checks++; if (ret_cnt !== 5 || {hp_bvalid, cqdb_sqhead} !== 5'b0_0101) begin errors++; $display("FAIL dup_retire: got cnt=%0d hp=%b head=%0d want 5 0 5", ret_cnt, hp_bvalid, cqdb_sqhead); end
        aw(4'h6); wb(ent(5, 1'b1, 15'h0), 1'b1); bb();
        aw(4'h6);
        hp_bready = 1'b1;
        wb(ent(5, 1'b1, 15'h0), 1'b1);
        hp_bready = 1'b0;
        bb();
        checks++; if (err_count !== 16'h2 || ret_cnt !== 6 || hp_bvalid !== 1'b0) begin errors++; $display("FAIL dup_same_cycle: got err=%0d cnt=%0d hp=%b want 2 6 0", err_count, ret_cnt, hp_bvalid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        nl_awready = 1'b0;
        aw(4'h7);
        wb(ent(0, 1'b1, 15'h0), 1'b0);
        cycles(2);
        checks++; if ({hp_bvalid, nl_awvalid, ns_wready} !== 3'b111) begin errors++; $display("FAIL mid_setup: got %b want 111", {hp_bvalid, nl_awvalid, ns_wready}); end
        #2 rstn = 1'b0;
        #1;
        checks++; if ({ns_awready, ns_wready, ns_bvalid, hp_bvalid, nl_awvalid, nl_wvalid, nl_bready} !== 7'b1000000) begin errors++; $display("FAIL mid_async: got %b want 1000000", {ns_awready, ns_wready, ns_bvalid, hp_bvalid, nl_awvalid, nl_wvalid, nl_bready}); end
        nl_awready = 1'b1;
        @(posedge clk);
        #1 rstn = 1'b1;
        cycles(6);
        checks++; if ({ns_awready, ns_bvalid, hp_bvalid, nl_awvalid, nl_wvalid, cqdb_sqhead, err_count} !== {5'b10000, 20'h0}) begin errors++; $display("FAIL mid_quiet: got %b %h %h", {ns_awready, ns_bvalid, hp_bvalid, nl_awvalid, nl_wvalid}, cqdb_sqhead, err_count); end
        checks++; if (ret_cnt !== 0 || nsb_cnt !== 0 || db_aw_cnt !== 0 || db_w_cnt !== 0) begin errors++; $display("FAIL mid_no_partial: got ret=%0d nsb=%0d aw=%0d w=%0d want 0", ret_cnt, nsb_cnt, db_aw_cnt, db_w_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_out_of_order();
        test_status();
        test_wrap();
        test_coalesce();
        test_duplicate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
